// File: rtl/bus_timer_if.sv
// Slave-side bus between the CPU data-bus bridge and bus_timer:
// word address/write strobe toward the timer, read data and IRQ back.
interface bus_timer_if;
    logic [31:0] addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    modport master (output addr, output WE, output WD, input RD, input IRQ);
    modport slave  (input addr, input WE, input WD, output RD, output IRQ);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers in a 16-byte window,
// one-shot or auto-reload countdown, registered interrupt request.
module bus_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic       clk,
    input  logic       reset,
    bus_timer_if.slave bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

    state_e        state_q;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] preset_q, preset_d;
    logic [DW-1:0] count_q;
    logic          irq_flag_q, irq_flag_d;
    logic          irq_q, irq_d;

    logic          hit;
    logic [1:0]    offset;
    logic          wr_ctrl, wr_preset;
    logic          en, auto_reload;
    logic          cnt_expire, int_oneshot, int_auto;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^bus.addr[1:0];

    // Address decode and FSM-derived qualifiers
    always_comb begin
        hit         = (bus.addr[DW-1:4] == BASE[DW-1:4]);
        offset      = bus.addr[3:2];
        wr_ctrl     = hit && bus.WE && (offset == 2'd0);
        wr_preset   = hit && bus.WE && (offset == 2'd1);
        en          = ctrl_q[0];
        auto_reload = (ctrl_q[2:1] == 2'b01);
        cnt_expire  = (state_q == CNT) && en && (count_q <= DW'(1));
        int_oneshot = (state_q == INT) && !auto_reload;
        int_auto    = (state_q == INT) && auto_reload;
    end

    // Register-file next state; CPU CTRL write beats the hardware EN clear,
    // and a hardware flag set beats the CPU-write clear.
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        irq_flag_d = irq_flag_q;
        if (int_oneshot) begin
            ctrl_d[0] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = bus.WD[CW-1:0];
        end
        if (wr_preset) begin
            preset_d = bus.WD;
        end
        if (wr_ctrl || wr_preset || int_auto) begin
            irq_flag_d = 1'b0;
        end
        if (cnt_expire) begin
            irq_flag_d = 1'b1;
        end
        irq_d = irq_flag_d & ctrl_d[3];
    end

    // Combinational read mux; misses and the reserved slot read zero
    always_comb begin
        bus.RD = '0;
        if (hit) begin
            case (offset)
                2'd0:    bus.RD = {{(DW-CW){1'b0}}, ctrl_q};
                2'd1:    bus.RD = preset_q;
                2'd2:    bus.RD = count_q;
                default: bus.RD = '0;
            endcase
        end
    end

    assign bus.IRQ = irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (count_q > DW'(1)) begin
                        count_q <= count_q - DW'(1);
                    end else begin
                        count_q <= '0;
                        state_q <= INT;
                    end
                end
                INT: begin
                    state_q <= auto_reload ? LOAD : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
